// File: rtl/evg_heartbeat_pacer.sv
// Heartbeat / sequence-start pacer for the event generator, evgTxClk domain.
// Optional build macro: EVG_PACER_PPS_CHECK_EN (PPS misalignment check and re-phase).
module evg_heartbeat_pacer #(
  parameter int INTERVAL_WIDTH = 32,
  parameter int SEQDIV_WIDTH   = 16,
  parameter int ERRCOUNT_WIDTH = 16
) (
  input  logic                      evgTxClk,
  input  logic                      evgReset,
  input  logic                      evgPPStoggle,
  input  logic                      cfgEnable,
  input  logic [INTERVAL_WIDTH-1:0] cfgHeartbeatInterval,
  input  logic [SEQDIV_WIDTH-1:0]   cfgSequenceDivisor,
  output logic                      evgHeartbeatRequest,
  output logic                      evgSequenceStart,
  output logic                      evgSynced,
  output logic [ERRCOUNT_WIDTH-1:0] evgPPSErrorCount
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_PPS = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;

  localparam logic [INTERVAL_WIDTH-1:0] HB_ONE  = {{(INTERVAL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INTERVAL_WIDTH-1:0] HB_MIN  = {{(INTERVAL_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [SEQDIV_WIDTH-1:0]   SEQ_ONE = {{(SEQDIV_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                state;
  logic [1:0]                stateNext;
  logic [INTERVAL_WIDTH-1:0] hbCnt;
  logic [INTERVAL_WIDTH-1:0] hbCntNext;
  logic [SEQDIV_WIDTH-1:0]   seqCnt;
  logic [SEQDIV_WIDTH-1:0]   seqCntNext;
  logic [SEQDIV_WIDTH-1:0]   seqCur;
  logic                      ppsD;
  logic                      ppsEdge;
  logic                      hbFire;
  logic                      seqFire;
`ifdef EVG_PACER_PPS_CHECK_EN
  logic                      ppsMisaligned;
  logic [ERRCOUNT_WIDTH-1:0] errCount;
`endif

  // Intervals below 2 ticks are clamped so the countdown always has a zero phase.
  function automatic logic [INTERVAL_WIDTH-1:0] reloadValue(input logic [INTERVAL_WIDTH-1:0] n);
    if (n < HB_MIN) begin
      reloadValue = HB_ONE;
    end else begin
      reloadValue = n - HB_ONE;
    end
  endfunction

  assign ppsEdge = evgPPStoggle ^ ppsD;

  // Next-state, countdown and pulse-cause decode.
  always_comb begin
    stateNext  = state;
    hbCntNext  = hbCnt;
    seqCntNext = seqCnt;
    seqCur     = seqCnt;
    hbFire     = 1'b0;
    seqFire    = 1'b0;
`ifdef EVG_PACER_PPS_CHECK_EN
    ppsMisaligned = 1'b0;
`endif
    if (!cfgEnable) begin
      stateNext  = IDLE;
      hbCntNext  = '0;
      seqCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          stateNext = WAIT_PPS;
        end
        WAIT_PPS: begin
          if (ppsEdge) begin
            hbFire    = 1'b1;
            seqCur    = '0;
            stateNext = RUN;
          end else begin
            stateNext = WAIT_PPS;
          end
        end
        RUN: begin
`ifdef EVG_PACER_PPS_CHECK_EN
          if (ppsEdge) begin
            hbFire        = 1'b1;
            ppsMisaligned = (hbCnt != '0);
          end else if (hbCnt == '0) begin
            hbFire = 1'b1;
          end else begin
            hbCntNext = hbCnt - HB_ONE;
          end
`else
          if (hbCnt == '0) begin
            hbFire = 1'b1;
          end else begin
            hbCntNext = hbCnt - HB_ONE;
          end
`endif
        end
        default: begin
          stateNext  = IDLE;
          hbCntNext  = '0;
          seqCntNext = '0;
        end
      endcase

      // N and D are only consumed here, so mid-interval changes wait for the reload.
      if (hbFire) begin
        hbCntNext = reloadValue(cfgHeartbeatInterval);
        if (cfgSequenceDivisor == '0) begin
          seqCntNext = seqCur;
        end else if (seqCur == '0) begin
          seqFire    = 1'b1;
          seqCntNext = cfgSequenceDivisor - SEQ_ONE;
        end else begin
          seqCntNext = seqCur - SEQ_ONE;
        end
      end else begin
        seqFire = 1'b0;
      end
    end
  end

  // State, counters, PPS sample and registered pulse outputs.
  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) begin
      state               <= IDLE;
      hbCnt               <= '0;
      seqCnt              <= '0;
      ppsD                <= 1'b0;
      evgHeartbeatRequest <= 1'b0;
      evgSequenceStart    <= 1'b0;
      evgSynced           <= 1'b0;
    end else begin
      state               <= stateNext;
      hbCnt               <= hbCntNext;
      seqCnt              <= seqCntNext;
      ppsD                <= evgPPStoggle;
      evgHeartbeatRequest <= hbFire;
      evgSequenceStart    <= seqFire;
      evgSynced           <= (stateNext == RUN);
    end
  end

`ifdef EVG_PACER_PPS_CHECK_EN
  // Saturating misaligned-PPS counter; only reset clears it.
  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) begin
      errCount <= '0;
    end else if (ppsMisaligned && (errCount != '1)) begin
      errCount <= errCount + {{(ERRCOUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      errCount <= errCount;
    end
  end

  assign evgPPSErrorCount = errCount;
`else
  assign evgPPSErrorCount = '0;
`endif

endmodule

// File: tb/tb_evg_heartbeat_pacer.sv
// Directed bench for evg_heartbeat_pacer; expectations follow EVG_PACER_PPS_CHECK_EN.
module tb_evg_heartbeat_pacer;

  logic        evgTxClk = 1'b0;
  logic        evgReset = 1'b1;
  logic        evgPPStoggle = 1'b0;
  logic        cfgEnable = 1'b0;
  logic [31:0] cfgHeartbeatInterval = 32'd10;
  logic [15:0] cfgSequenceDivisor = 16'd0;
  logic        evgHeartbeatRequest;
  logic        evgSequenceStart;
  logic        evgSynced;
  logic [15:0] evgPPSErrorCount;

  int total = 0;
  int bad   = 0;

  always #5 evgTxClk = ~evgTxClk;

  evg_heartbeat_pacer #(
    .INTERVAL_WIDTH(32),
    .SEQDIV_WIDTH(16),
    .ERRCOUNT_WIDTH(16)
  ) dut (
    .evgTxClk(evgTxClk),
    .evgReset(evgReset),
    .evgPPStoggle(evgPPStoggle),
    .cfgEnable(cfgEnable),
    .cfgHeartbeatInterval(cfgHeartbeatInterval),
    .cfgSequenceDivisor(cfgSequenceDivisor),
    .evgHeartbeatRequest(evgHeartbeatRequest),
    .evgSequenceStart(evgSequenceStart),
    .evgSynced(evgSynced),
    .evgPPSErrorCount(evgPPSErrorCount)
  );

  task automatic step();
    @(posedge evgTxClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectOut(input string tag, input int k, input logic hb, input logic seq, input logic sync);
    check($sformatf("%s k=%0d hb", tag, k), {31'd0, evgHeartbeatRequest}, {31'd0, hb});
    check($sformatf("%s k=%0d seq", tag, k), {31'd0, evgSequenceStart}, {31'd0, seq});
    check($sformatf("%s k=%0d sync", tag, k), {31'd0, evgSynced}, {31'd0, sync});
  endtask

  task automatic doReset();
    evgReset     = 1'b1;
    cfgEnable    = 1'b0;
    evgPPStoggle = 1'b0;
    step();
    step();
    evgReset = 1'b0;
  endtask

  // Enable, let the FSM reach WAIT_PPS, then toggle PPS; k=0 is the first heartbeat.
  task automatic syncUp(input string tag, input logic [31:0] n, input logic [15:0] d);
    cfgHeartbeatInterval = n;
    cfgSequenceDivisor   = d;
    cfgEnable            = 1'b1;
    step();
    expectOut({tag, " enter"}, -1, 1'b0, 1'b0, 1'b0);
    evgPPStoggle = ~evgPPStoggle;
    step();
    expectOut(tag, 0, 1'b1, (d != 16'd0), 1'b1);
  endtask

  initial begin
    // Reset held while PPS toggles and enable is high.
    evgReset  = 1'b1;
    cfgEnable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      evgPPStoggle = ~evgPPStoggle;
      step();
      expectOut("t1 reset", k, 1'b0, 1'b0, 1'b0);
      check($sformatf("t1 reset k=%0d err", k), {16'd0, evgPPSErrorCount}, 32'd0);
    end

    // N=10, D=3: heartbeats every 10, sequence start on 1st and 4th.
    doReset();
    syncUp("t2", 32'd10, 16'd3);
    for (int k = 1; k <= 45; k++) begin
      step();
      expectOut("t2", k, (k % 10 == 0), (k == 30), 1'b1);
    end

    // N=10, D=0, PPS on the heartbeat grid every 50 cycles.
    doReset();
    syncUp("t3", 32'd10, 16'd0);
    for (int k = 1; k <= 100; k++) begin
      step();
      expectOut("t3", k, (k % 10 == 0), 1'b0, 1'b1);
      if (k % 50 == 49) evgPPStoggle = ~evgPPStoggle;
    end
    check("t3 err", {16'd0, evgPPSErrorCount}, 32'd0);

    // PPS edge 3 cycles before the heartbeat at k=10.
    doReset();
    syncUp("t4", 32'd10, 16'd0);
    for (int k = 1; k <= 30; k++) begin
      step();
`ifdef EVG_PACER_PPS_CHECK_EN
      expectOut("t4", k, (k == 7 || k == 17 || k == 27), 1'b0, 1'b1);
      if (k == 7) check("t4 err@7", {16'd0, evgPPSErrorCount}, 32'd1);
`else
      expectOut("t4", k, (k % 10 == 0), 1'b0, 1'b1);
      if (k == 7) check("t4 err@7", {16'd0, evgPPSErrorCount}, 32'd0);
`endif
      if (k == 6) evgPPStoggle = ~evgPPStoggle;
    end
`ifdef EVG_PACER_PPS_CHECK_EN
    check("t4 err end", {16'd0, evgPPSErrorCount}, 32'd1);
`else
    check("t4 err end", {16'd0, evgPPSErrorCount}, 32'd0);
`endif

    // Drop enable 2 cycles before the heartbeat due at k=10, then re-enable.
    doReset();
    syncUp("t5", 32'd10, 16'd0);
    for (int k = 1; k <= 7; k++) begin
      step();
      expectOut("t5 run", k, 1'b0, 1'b0, 1'b1);
    end
    cfgEnable = 1'b0;
    step();
    expectOut("t5 drop", 8, 1'b0, 1'b0, 1'b0);
    evgPPStoggle = ~evgPPStoggle;
    for (int k = 9; k <= 12; k++) begin
      step();
      expectOut("t5 idle", k, 1'b0, 1'b0, 1'b0);
    end
    cfgEnable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      expectOut("t5 wait", k, 1'b0, 1'b0, 1'b0);
    end
    evgPPStoggle = ~evgPPStoggle;
    step();
    expectOut("t5 resync", 0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      expectOut("t5 after", k, (k == 10), 1'b0, 1'b1);
    end

    // N 10 -> 4 mid-interval, then N=1 clamps to 2-cycle spacing.
    doReset();
    syncUp("t6", 32'd10, 16'd0);
    for (int k = 1; k <= 34; k++) begin
      step();
      expectOut("t6", k, (k == 10 || k == 14 || k == 18 || k == 22 || k == 26 ||
                          k == 28 || k == 30 || k == 32 || k == 34), 1'b0, 1'b1);
      if (k == 3) cfgHeartbeatInterval = 32'd4;
      if (k == 22) cfgHeartbeatInterval = 32'd1;
    end

    // N=2, D=1: every heartbeat carries a sequence start; async reset drops the pulse.
    doReset();
    syncUp("t7", 32'd2, 16'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      expectOut("t7", k, (k % 2 == 0), (k % 2 == 0), 1'b1);
    end
    evgReset = 1'b1;
    #1;
    expectOut("t7 async rst", 9, 1'b0, 1'b0, 1'b0);
    evgReset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
